// File: rtl/rom_load_arbiter.sv
// HPS "Load ROM" sequencer and single-port arbiter for the PC-8001 ROM store.
// Optional feature: define ROM_LOAD_CHECKSUM_EN to add a 16-bit sum of accepted bytes.
`timescale 1ns/1ps

module rom_load_arbiter #(
  parameter int ADDR_W      = 15,
  parameter int ROM_SIZE    = 32768,
  parameter int INDEX       = 1,
  parameter int HOLD_CYCLES = 1024
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic [7:0]        cpu_dout,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  output logic              mem_we,
  input  logic [7:0]        mem_dout,
  output logic              core_reset_n,
  output logic              load_done,
  output logic              overflow,
`ifdef ROM_LOAD_CHECKSUM_EN
  output logic [15:0]       checksum,
`endif
  output logic [1:0]        dbg_state_o
);

  // cpu_req/cpu_ack handshake: the requester holds cpu_req until it sees a
  // one-cycle cpu_ack; a request is taken only in IDLE with the access slot
  // free, so cpu_req still high during the ack cycle is never a new request.

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    CPU_READY = 2'd0,
    CPU_ISSUE = 2'd1,
    CPU_ACK   = 2'd2
  } cpu_phase_t;

  localparam int               CNT_W     = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [25:0]      ROM_LIMIT = 26'(ROM_SIZE);

  state_t            state_q, state_d;
  cpu_phase_t        phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_din_q, mem_din_d;
  logic              mem_we_q, mem_we_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              core_reset_n_q, core_reset_n_d;
  logic              load_done_q, load_done_d;
  logic              loaded_q, loaded_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       checksum_q, checksum_d;

  logic ld_match;
  logic enter_load;
  logic in_range;
  logic unused_index_hi;

  assign ld_match   = ioctl_download && (ioctl_index[5:0] == 6'(INDEX));
  assign enter_load = ld_match && (state_q != ST_LOAD);
  assign in_range   = ({1'b0, ioctl_addr} < ROM_LIMIT);
  assign unused_index_hi = ^ioctl_index[7:6];

  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    cnt_d          = cnt_q;
    mem_addr_d     = mem_addr_q;
    mem_din_d      = mem_din_q;
    mem_we_d       = 1'b0;
    cpu_ack_d      = 1'b0;
    core_reset_n_d = core_reset_n_q;
    load_done_d    = load_done_q;
    loaded_d       = loaded_q;
    overflow_d     = overflow_q;
    checksum_d     = checksum_q;

    case (state_q)
      ST_IDLE: begin
        if (!enter_load) begin
          case (phase_q)
            CPU_READY: begin
              if (cpu_req) begin
                mem_addr_d = cpu_addr;
                mem_din_d  = cpu_din;
                mem_we_d   = cpu_we;
                phase_d    = CPU_ISSUE;
              end
            end
            CPU_ISSUE: begin
              cpu_ack_d = 1'b1;
              phase_d   = CPU_ACK;
            end
            default: phase_d = CPU_READY;
          endcase
        end
      end

      ST_LOAD: begin
        // A strobe in the same cycle the download drops is still honoured.
        if (ioctl_wr) begin
          if (in_range) begin
            mem_addr_d = ioctl_addr[ADDR_W-1:0];
            mem_din_d  = ioctl_dout;
            mem_we_d   = 1'b1;
            checksum_d = checksum_q + {8'h00, ioctl_dout};
          end else begin
            overflow_d = 1'b1;
          end
        end
        if (!ioctl_download) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end

      ST_HOLD: begin
        if (!enter_load) begin
          if (cnt_q == CNT_LAST) begin
            state_d        = ST_IDLE;
            core_reset_n_d = 1'b1;
            load_done_d    = load_done_q | loaded_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = ST_HOLD;
    endcase

    // Starting a download drops any half-finished CPU access without an ack.
    if (enter_load) begin
      state_d        = ST_LOAD;
      phase_d        = CPU_READY;
      mem_we_d       = 1'b0;
      cpu_ack_d      = 1'b0;
      core_reset_n_d = 1'b0;
      overflow_d     = 1'b0;
      loaded_d       = 1'b1;
      checksum_d     = 16'h0000;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q        <= ST_HOLD;
      phase_q        <= CPU_READY;
      cnt_q          <= '0;
      mem_addr_q     <= '0;
      mem_din_q      <= 8'h00;
      mem_we_q       <= 1'b0;
      cpu_ack_q      <= 1'b0;
      core_reset_n_q <= 1'b0;
      load_done_q    <= 1'b0;
      loaded_q       <= 1'b0;
      overflow_q     <= 1'b0;
      checksum_q     <= 16'h0000;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      cnt_q          <= cnt_d;
      mem_addr_q     <= mem_addr_d;
      mem_din_q      <= mem_din_d;
      mem_we_q       <= mem_we_d;
      cpu_ack_q      <= cpu_ack_d;
      core_reset_n_q <= core_reset_n_d;
      load_done_q    <= load_done_d;
      loaded_q       <= loaded_d;
      overflow_q     <= overflow_d;
      checksum_q     <= checksum_d;
    end
  end

  // The RAM returns data one cycle after the address, which lines up with the
  // ack cycle, so read data is passed through rather than re-registered.
  assign cpu_dout     = cpu_ack_q ? mem_dout : 8'h00;
  assign cpu_ack      = cpu_ack_q;
  assign mem_addr     = mem_addr_q;
  assign mem_din      = mem_din_q;
  assign mem_we       = mem_we_q;
  assign core_reset_n = core_reset_n_q;
  assign load_done    = load_done_q;
  assign overflow     = overflow_q;
  assign dbg_state_o  = state_q;

`ifdef ROM_LOAD_CHECKSUM_EN
  assign checksum = checksum_q;
`else
  logic unused_checksum;
  assign unused_checksum = ^checksum_q;
`endif

endmodule

// File: doc/rom_load_arbiter.md
# rom_load_arbiter

Sequences HPS ROM downloads (the "Load ROM" file entry) into the PC-8001 boot/expansion ROM store and shares that store's single synchronous RAM port between the loader and the Z80 memory path. While a matching download runs, the block owns the RAM, holds the core in reset, and drops out-of-range bytes. After the download it keeps reset asserted for a fixed settle time, then hands the port back to the CPU.

## Interface
- `ADDR_W`, default 15: ROM store address width (32 KiB).
- `ROM_SIZE`, default 32768: accepted byte count. Must be ≤ 2^ADDR_W.
- `INDEX`, default 1: `ioctl_index[5:0]` value that selects this loader.
- `HOLD_CYCLES`, default 1024: core-reset settle time after a download, in clocks. Must be ≥ 1.
- `clk_sys` in 1: single clock.
- `reset_n` in 1: synchronous, active-low reset.
- `ioctl_download` in 1: HPS download active.
- `ioctl_index` in 8: download file index.
- `ioctl_wr` in 1: one-cycle byte strobe.
- `ioctl_addr` in 25: byte address.
- `ioctl_dout` in 8: byte data.
- `cpu_req` in 1: CPU access request, held until `cpu_ack`.
- `cpu_we` in 1: 1 = write.
- `cpu_addr` in ADDR_W: CPU address.
- `cpu_din` in 8: CPU write data.
- `cpu_dout` out 8: read data, valid while `cpu_ack`.
- `cpu_ack` out 1: one-cycle completion pulse.
- `mem_addr` out ADDR_W: RAM address, registered.
- `mem_din` out 8: RAM write data, registered.
- `mem_we` out 1: RAM write enable, registered.
- `mem_dout` in 8: RAM read data, 1-cycle latency.
- `core_reset_n` out 1: active-low reset to the pc8001m core.
- `load_done` out 1: at least one download has completed since reset.
- `overflow` out 1: a byte at or above ROM_SIZE was dropped in the current or last download.

## Operation
- FSM with three states: IDLE (CPU owns the port), LOAD, HOLD.
- Reset enters HOLD with counter = 0. Reset values: `core_reset_n`=0, `cpu_ack`=0, `cpu_dout`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0, `load_done`=0, `overflow`=0.
- IDLE → LOAD when `ioctl_download`=1 and `ioctl_index[5:0]`=INDEX. Entering LOAD clears `overflow`, drives `core_reset_n`=0, and abandons any in-flight CPU access without an ack.
- Downloads with any other index are ignored. The block stays in IDLE.
- In LOAD, each `ioctl_wr` with `ioctl_addr` < ROM_SIZE registers `mem_addr`=`ioctl_addr[ADDR_W-1:0]`, `mem_din`=`ioctl_dout`, `mem_we`=1 for exactly one cycle.
- An `ioctl_wr` with `ioctl_addr` ≥ ROM_SIZE writes nothing and sets `overflow`.
- LOAD → HOLD on `ioctl_download`=0. The counter clears.
- HOLD counts up to HOLD_CYCLES-1, then goes to IDLE, sets `load_done`=1 (sticky until reset) and `core_reset_n`=1. If no download has occurred since reset, `load_done` stays 0.
- HOLD → LOAD if a matching download starts during HOLD. The counter restarts on the next exit from LOAD.
- CPU path, IDLE only: a request accepted in cycle N drives `mem_addr`/`mem_we`/`mem_din` at N+1. `cpu_ack`=1 and `cpu_dout`=`mem_dout` at N+2.
- A new request is accepted no earlier than N+3. `cpu_req` high in the ack cycle is not a new request.
- `cpu_req` in LOAD or HOLD is never acked.

## Timing
- Loader write latency: `ioctl_wr` at cycle N → `mem_we` high during N+1 only.
- Back-to-back `ioctl_wr` on consecutive cycles is supported. Each byte is written, with no drops.
- `ioctl_wr` in the same cycle as `ioctl_download` falls is still written. The transition to HOLD takes effect at N+1.
- `core_reset_n` changes only on registered edges. It is low from the cycle after download start until HOLD_CYCLES cycles after download end.
- CPU read latency: 2 cycles from accept to ack. Throughput: one access per 3 cycles.
- `reset_n` low mid-LOAD: all outputs return to reset values at the next edge, with no partial write pending.

## Configuration
- `ROM_LOAD_CHECKSUM_EN` defined: adds output `checksum` [15:0]. It is cleared on LOAD entry and holds the 16-bit wrap-around sum of all accepted (in-range) bytes, updated in the same cycle as `mem_we`. Reset value is 0.
- Without the macro: the port and adder are absent, and all other behaviour is identical.

## Test plan
- Reset release with no download → `core_reset_n` goes 1 after 1024 cycles, `load_done`=0.
- Matching download (index 1) of bytes 0x00..0xFF at addr 0..255 → 256 single-cycle `mem_we` pulses, each 1 cycle after its `ioctl_wr`. After the download ends, `core_reset_n`=1 after 1024 cycles, `load_done`=1. With the macro, `checksum`=0x7F80.
- Write at `ioctl_addr`=0x8000 → no `mem_we`, `overflow`=1. A later download clears `overflow`.
- Download with index 2 → FSM stays IDLE, `core_reset_n` stays 1, no `mem_we`.
- CPU write 0xA5 to 0x0100, then read 0x0100 → read ack 2 cycles after accept, `cpu_dout`=0xA5. `cpu_req` during LOAD → no ack.
- `reset_n` low mid-download, then a new download starts during HOLD → outputs at reset values, and the block returns to LOAD without reaching IDLE.
